// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// cpu_sequencer_if : sequencer <-> datapath/memory control bus     Rev 1.0
// ============================================================================
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             alu_src_b;
  logic [2:0]       alu_ctl;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
           reg_dst, wd_sel, alu_src_b, alu_ctl, halted, retired, state
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
           reg_dst, wd_sel, alu_src_b, alu_ctl, halted, retired, state
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : multicycle MIPS control FSM with retired counter  Rev 1.0
// ============================================================================
module cpu_sequencer #(
  parameter int CNT_W = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  cpu_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  EXEC_I = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, HALT   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08, FN_ADD  = 6'h20, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [2:0] ALU_ADD  = 3'b000, ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010, ALU_SLT = 3'b011;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d, fn_q, fn_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             r_type;
  logic [2:0]       exec_ctl;

  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
  logic       alu_src_b, halted;
  logic [1:0] pc_src, reg_dst, wd_sel;
  logic [2:0] alu_ctl;

  // ALU op is derived from the latched instruction so ALUWB can hold it.
  always_comb begin
    r_type   = (op_q == OP_RTYPE);
    exec_ctl = ALU_ADD;
    if (r_type) begin
      if (fn_q == FN_SUB)      exec_ctl = ALU_SUB;
      else if (fn_q == FN_SLT) exec_ctl = ALU_SLT;
    end else if (op_q == OP_XORI) begin
      exec_ctl = ALU_XOR;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    alu_src_b = 1'b0;
    alu_ctl   = ALU_ADD;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        case (bus.opcode)
          OP_LW, OP_SW:      state_d = MEMADR;
          OP_BEQ, OP_BNE:    state_d = BRANCH;
          OP_ADDI, OP_XORI:  state_d = EXEC_I;
          OP_J, OP_JAL:      state_d = JUMP;
          OP_RTYPE: begin
            case (bus.funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = EXEC_R;
              FN_JR:                  state_d = JUMP;
              default:                state_d = HALT;
            endcase
          end
          default:           state_d = HALT;
        endcase
      end
      MEMADR: begin
        alu_src_b = 1'b1;
        state_d   = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write = 1'b1;
        wd_sel    = 2'd1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC_R, EXEC_I: begin
        alu_src_b = ~r_type;
        alu_ctl   = exec_ctl;
        state_d   = ALUWB;
      end
      ALUWB: begin
        alu_src_b = ~r_type;
        alu_ctl   = exec_ctl;
        reg_write = 1'b1;
        reg_dst   = r_type ? 2'd1 : 2'd0;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_ctl  = ALU_SUB;
        pc_src   = 2'd1;
        pc_write = (op_q == OP_BEQ) ? bus.alu_zero : ~bus.alu_zero;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
        if (op_q == OP_JAL) begin
          pc_src    = 2'd2;
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wd_sel    = 2'd2;
        end else if (op_q == OP_J) begin
          pc_src = 2'd2;
        end else begin
          pc_src = 2'd3;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      retired_q <= retired_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.i_or_d    = i_or_d;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.reg_write = reg_write;
  assign bus.reg_dst   = reg_dst;
  assign bus.wd_sel    = wd_sel;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_ctl   = alu_ctl;
  assign bus.halted    = halted;
  assign bus.retired   = retired_q;
  assign bus.state     = state_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : directed vector bench for cpu_sequencer         Rev 1.0
// ============================================================================
module tb_cpu_sequencer;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(CNT_W)) b ();
  cpu_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(b));

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       az;
    int cyc, st2, rw, rd, wd, pw, ps, ctl, srcb, we;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int r_cyc, r_memcyc, r_stray, r_fetch_bad, r_st2;
  int l_st, l_rw, l_rd, l_wd, l_pw, l_ps, l_ctl, l_srcb, l_we, l_ir;

  // A negative expected value marks a don't-care field.
  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                           input int fwait, input int mwait);
    int fw = fwait;
    int mw = mwait;
    bit scramble = 1'b0;
    bit done = 1'b0;
    r_cyc = 0; r_memcyc = 0; r_stray = 0; r_fetch_bad = 0; r_st2 = -1; l_st = -1;
    b.opcode = op; b.funct = fn; b.alu_zero = az;
    while (!done) begin
      if (r_cyc > 0 && b.state == 4'd0 && l_st != 0) begin
        done = 1'b1;
      end else if (r_cyc >= 40) begin
        checks++; errors++;
        $display("FAIL instr_timeout: op=%02h got %0d cycles, required return to FETCH", op, r_cyc);
        done = 1'b1;
      end else begin
        if (scramble) begin b.opcode = 6'h3F; b.funct = 6'h3F; end
        if (b.state == 4'd0) begin
          b.mem_ready = (fw == 0); if (fw > 0) fw--;
        end else if (b.state == 4'd3 || b.state == 4'd5) begin
          b.mem_ready = (mw == 0); if (mw > 0) mw--;
        end else begin
          b.mem_ready = 1'b1;
        end
        #1;
        scramble = (b.state == 4'd1);
        if (r_cyc == 2) r_st2 = b.state;
        if (b.mem_req && b.i_or_d) r_memcyc++;
        if (b.state == 4'd0) begin
          if (b.mem_ready)
            r_fetch_bad += int'(!b.ir_write || !b.pc_write || b.pc_src != 2'd0 ||
                                b.i_or_d || !b.mem_req);
          else
            r_fetch_bad += int'(b.ir_write || b.pc_write);
        end
        if (b.state != 4'd0 && l_st > 0) r_stray += int'(l_rw != 0 || l_pw != 0 || l_ir != 0);
        l_st = b.state; l_rw = b.reg_write; l_rd = b.reg_dst; l_wd = b.wd_sel;
        l_pw = b.pc_write; l_ps = b.pc_src; l_ctl = b.alu_ctl; l_srcb = b.alu_src_b;
        l_we = b.mem_we; l_ir = b.ir_write;
        r_cyc++;
        @(negedge clk);
      end
    end
    exp_ret = (exp_ret + 1) % 16;
  endtask

  vec_t tbl [14];

  initial begin
    //            op     fn     az   cyc st2 rw  rd  wd  pw  ps  ctl srcb we
    tbl[0]  = '{6'h00, 6'h20, 1'b0, 4,  6,  1,  1,  0,  0, -1,  0,  0,  0};
    tbl[1]  = '{6'h00, 6'h22, 1'b0, 4,  6,  1,  1,  0,  0, -1,  1,  0,  0};
    tbl[2]  = '{6'h00, 6'h2A, 1'b0, 4,  6,  1,  1,  0,  0, -1,  3,  0,  0};
    tbl[3]  = '{6'h08, 6'h00, 1'b0, 4,  7,  1,  0,  0,  0, -1,  0,  1,  0};
    tbl[4]  = '{6'h0E, 6'h00, 1'b0, 4,  7,  1,  0,  0,  0, -1,  2,  1,  0};
    tbl[5]  = '{6'h23, 6'h00, 1'b0, 5,  2,  1,  0,  1,  0, -1, -1, -1,  0};
    tbl[6]  = '{6'h2B, 6'h00, 1'b0, 4,  2,  0, -1, -1,  0, -1, -1, -1,  1};
    tbl[7]  = '{6'h04, 6'h00, 1'b1, 3,  9,  0, -1, -1,  1,  1,  1,  0,  0};
    tbl[8]  = '{6'h04, 6'h00, 1'b0, 3,  9,  0, -1, -1,  0,  1,  1,  0,  0};
    tbl[9]  = '{6'h05, 6'h00, 1'b1, 3,  9,  0, -1, -1,  0,  1,  1,  0,  0};
    tbl[10] = '{6'h05, 6'h00, 1'b0, 3,  9,  0, -1, -1,  1,  1,  1,  0,  0};
    tbl[11] = '{6'h02, 6'h00, 1'b0, 3, 10,  0, -1, -1,  1,  2, -1, -1,  0};
    tbl[12] = '{6'h03, 6'h00, 1'b0, 3, 10,  1,  2,  2,  1,  2, -1, -1,  0};
    tbl[13] = '{6'h00, 6'h08, 1'b0, 3, 10,  0, -1, -1,  1,  3, -1, -1,  0};

    b.opcode = 6'h00; b.funct = 6'h00; b.alu_zero = 1'b0; b.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", b.state, 0);
    chk("reset_retired", b.retired, 0);
    chk("reset_enables", {b.ir_write, b.pc_write, b.reg_write, b.mem_we}, 0);
    chk("reset_muxes", {b.pc_src, b.reg_dst, b.wd_sel, b.alu_ctl}, 0);
    chk("reset_halted", b.halted, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].az, 0, 0);
      chk($sformatf("row%0d cycles", i), r_cyc, tbl[i].cyc);
      chk($sformatf("row%0d state2", i), r_st2, tbl[i].st2);
      chk($sformatf("row%0d reg_write", i), l_rw, tbl[i].rw);
      chk($sformatf("row%0d reg_dst", i), l_rd, tbl[i].rd);
      chk($sformatf("row%0d wd_sel", i), l_wd, tbl[i].wd);
      chk($sformatf("row%0d pc_write", i), l_pw, tbl[i].pw);
      chk($sformatf("row%0d pc_src", i), l_ps, tbl[i].ps);
      chk($sformatf("row%0d alu_ctl", i), l_ctl, tbl[i].ctl);
      chk($sformatf("row%0d alu_src_b", i), l_srcb, tbl[i].srcb);
      chk($sformatf("row%0d mem_we", i), l_we, tbl[i].we);
      chk($sformatf("row%0d stray_enables", i), r_stray, 0);
      chk($sformatf("row%0d fetch_outputs", i), r_fetch_bad, 0);
      chk($sformatf("row%0d retired", i), b.retired, exp_ret);
    end

    // Memory wait states on each request phase.
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    chk("lw_wait cycles", r_cyc, 8);
    chk("lw_wait mem_cycles", r_memcyc, 4);
    chk("lw_wait wd_sel", l_wd, 1);
    chk("lw_wait reg_dst", l_rd, 0);
    chk("lw_wait retired", b.retired, exp_ret);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 2);
    chk("sw_wait cycles", r_cyc, 6);
    chk("sw_wait mem_cycles", r_memcyc, 3);
    chk("sw_wait mem_we", l_we, 1);
    chk("sw_wait retired", b.retired, exp_ret);
    run_instr(6'h00, 6'h20, 1'b0, 2, 0);
    chk("fetch_wait cycles", r_cyc, 6);
    chk("fetch_wait outputs", r_fetch_bad, 0);

    // Reset while MEMRD is waiting with mem_req high.
    b.opcode = 6'h23; b.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    b.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("memrd_wait state", b.state, 3);
    chk("memrd_wait mem_req", b.mem_req, 1);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_memrd state", b.state, 0);
    chk("rst_memrd retired", b.retired, 0);
    chk("rst_memrd reg_write", b.reg_write, 0);
    reset = 1'b1; exp_ret = 0;
    @(negedge clk);

    // Counter wrap at CNT_W = 4.
    for (int i = 0; i < 15; i++) run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    chk("wrap pre", b.retired, 15);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    chk("wrap post", b.retired, 0);

    // Reset while FETCH is waiting.
    run_instr(6'h0E, 6'h00, 1'b0, 0, 0);
    b.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("fetch_hold retired", b.retired, 1);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_fetch state", b.state, 0);
    chk("rst_fetch retired", b.retired, 0);
    reset = 1'b1; exp_ret = 0;
    @(negedge clk);

    // syscall halts.
    b.opcode = 6'h00; b.funct = 6'h0C; b.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("syscall state", b.state, 11);
    chk("syscall halted", b.halted, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Illegal opcode halts and ignores mem_ready.
    b.opcode = 6'h3F; b.funct = 6'h00; b.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b.mem_ready = i[0];
      #1;
      chk($sformatf("halt%0d state", i), b.state, 11);
      chk($sformatf("halt%0d halted", i), b.halted, 1);
      chk($sformatf("halt%0d enables", i),
          {b.mem_req, b.ir_write, b.pc_write, b.reg_write, b.mem_we}, 0);
      chk($sformatf("halt%0d retired", i), b.retired, 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_halt state", b.state, 0);
    chk("rst_halt halted", b.halted, 0);
    chk("rst_halt retired", b.retired, 0);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
